dds_sine_scheduler: RTL and testbench

- Two-channel direct-digital-synthesis controller that time-shares one external 1024-entry, 16-bit signed sine lookup table with a combinational read.
- Per sample strobe it runs a phase accumulator for each channel and reads the table once per channel, channel 0 first.
- Both results are presented together with a one-cycle valid pulse.
- Feeds the waveform-generator inputs of the FIR/IIR filter datapath.

---
 rtl/dds_sine_scheduler.sv | 112 +++++++++++
 tb/tb_dds_sine_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sine_scheduler.sv
// Two-channel DDS controller sharing one combinational sine LUT.
// Per sample strobe it reads channel 0 and then channel 1, and presents both results with a single valid pulse.
module dds_sine_scheduler #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_tick,
  input  logic               i_sync,
  input  logic [PHASE_W-1:0] i_fcw0,
  input  logic [PHASE_W-1:0] i_fcw1,
  input  logic [ADDR_W-1:0]  i_off0,
  input  logic [ADDR_W-1:0]  i_off1,
  output logic [ADDR_W-1:0]  o_lut_addr,
  input  logic [DATA_W-1:0]  i_lut_data,
  output logic [DATA_W-1:0]  o_ch0_data,
  output logic [DATA_W-1:0]  o_ch1_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, COMMIT} state_e;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   acc0_q, acc0_d, acc1_q, acc1_d;
  logic [DATA_W-1:0]    stg0_q, stg0_d;
  logic [DATA_W-1:0]    ch0_q, ch0_d, ch1_q, ch1_d;
  logic                 ovr_q, ovr_d;
  logic [ADDR_W-1:0]    addr0, addr1, lut_addr;

  // Sample from the pre-increment phase; the ADDR_W-bit sum wraps around the table.
  assign addr0 = acc0_q[PHASE_W-1 -: ADDR_W] + i_off0;
  assign addr1 = acc1_q[PHASE_W-1 -: ADDR_W] + i_off1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc0_q  <= '0;
      acc1_q  <= '0;
      stg0_q  <= '0;
      ch0_q   <= '0;
      ch1_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      stg0_q  <= stg0_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    stg0_d   = stg0_q;
    ch0_d    = ch0_q;
    ch1_d    = ch1_q;
    lut_addr = '0;
    // A strobe is dropped if the sequencer is busy or if the strobe coincides with a phase clear.
    ovr_d    = ovr_q | (i_tick & i_en & (i_sync | (state_q != IDLE)));

    unique case (state_q)
      IDLE: begin
        if (i_tick && i_en && !i_sync) state_d = RD0;
      end
      RD0: begin
        lut_addr = addr0;
        stg0_d   = i_lut_data;
        acc0_d   = acc0_q + i_fcw0;
        state_d  = RD1;
      end
      RD1: begin
        lut_addr = addr1;
        ch0_d    = stg0_q;
        ch1_d    = i_lut_data;
        acc1_d   = acc1_q + i_fcw1;
        state_d  = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Phase clear wins over everything else: abandon the sequence and keep the last committed outputs.
    if (i_sync) begin
      acc0_d  = '0;
      acc1_d  = '0;
      ch0_d   = ch0_q;
      ch1_d   = ch1_q;
      state_d = IDLE;
    end
  end

  assign o_lut_addr = lut_addr;
  assign o_ch0_data = ch0_q;
  assign o_ch1_data = ch1_q;
  assign o_valid    = (state_q == COMMIT);
  assign o_busy     = (state_q != IDLE);
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_dds_sine_scheduler.sv
// Bench for dds_sine_scheduler: an identity LUT (data = address), a strobe-level reference model checked every cycle,
// and directed scenarios with literal expected values.
module tb_dds_sine_scheduler;

  logic        clk, rst, en, tick, sync;
  logic [31:0] fcw0, fcw1;
  logic [9:0]  off0, off1, lut_addr;
  logic [15:0] lut_data, ch0, ch1;
  logic        valid, busy, ovr;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_s    = 0;

  dds_sine_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_tick(tick), .i_sync(sync),
    .i_fcw0(fcw0), .i_fcw1(fcw1), .i_off0(off0), .i_off1(off1),
    .o_lut_addr(lut_addr), .i_lut_data(lut_data),
    .o_ch0_data(ch0), .o_ch1_data(ch1),
    .o_valid(valid), .o_busy(busy), .o_overrun(ovr)
  );

  assign lut_data = 16'(lut_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] addr_of(input logic [31:0] ph, input logic [9:0] off);
    return 10'(ph[31:22] + off);
  endfunction

  // Reference model: a strobe makes the unit busy for three cycles. Channel 0 is read in the first cycle and
  // channel 1 in the second; both results commit together, and valid is raised in the third cycle.
  logic [31:0] m_ph0, m_ph1;
  logic [15:0] m_stg, m_ch0, m_ch1;
  int          m_cnt;
  bit          m_ovr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph0 = '0; m_ph1 = '0; m_stg = '0; m_ch0 = '0; m_ch1 = '0; m_cnt = 0; m_ovr = 1'b0;
    end else begin
      if (tick && en && (m_cnt != 0 || sync)) m_ovr = 1'b1;
      if (sync) begin
        m_ph0 = '0; m_ph1 = '0; m_cnt = 0;
      end else begin
        case (m_cnt)
          0: if (tick && en) m_cnt = 3;
          3: begin
            m_stg = 16'(addr_of(m_ph0, off0));
            m_ph0 = m_ph0 + fcw0;
            m_cnt = 2;
          end
          2: begin
            m_ch0 = m_stg;
            m_ch1 = 16'(addr_of(m_ph1, off1));
            m_ph1 = m_ph1 + fcw1;
            m_cnt = 1;
          end
          default: m_cnt = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model valid",   valid, (m_cnt == 1) ? 1 : 0);
      chk("model busy",    busy,  (m_cnt != 0) ? 1 : 0);
      chk("model overrun", ovr,   m_ovr);
      chk("model ch0",     ch0,   m_ch0);
      chk("model ch1",     ch1,   m_ch1);
      chk("model addr",    lut_addr,
          (m_cnt == 3) ? addr_of(m_ph0, off0) : (m_cnt == 2) ? addr_of(m_ph1, off1) : 10'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
  endtask

  // Returns one time unit after the edge that samples the strobe, i.e. in the first read cycle.
  task automatic strobe();
    @(posedge clk); #1 tick = 1'b1; t_s = cyc;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [15:0] e0, input logic [15:0] e1);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
    chk({name, " valid seen"}, 32'(got), 1);
    if (got) begin
      chk({name, " latency"}, 32'(cyc - t_s), 3);
      chk({name, " ch0"}, ch0, e0);
      chk({name, " ch1"}, ch1, e1);
      @(negedge clk);
      chk({name, " valid width"}, valid, 0);
    end
  endtask

  task automatic count_valid(input int n, output int nv);
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    int exp0[5];
    int exp1[5];
    exp0 = '{1020, 1021, 1022, 1023, 0};
    exp1 = '{0, 1023, 1022, 1021, 1020};
    rst = 1'b0; en = 1'b0; tick = 1'b0; sync = 1'b0;
    fcw0 = '0; fcw1 = '0; off0 = '0; off1 = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ch0", ch0, 0);
    chk("reset ch1", ch1, 0);
    chk("reset valid/busy/ovr", {valid, busy, ovr}, 0);
    chk("reset addr", lut_addr, 0);
    rst = 1'b0;

    // Basic sequencing with a quarter-turn offset between the channels.
    en = 1'b1; fcw0 = 32'h0040_0000; fcw1 = 32'h0040_0000; off0 = 10'd0; off1 = 10'd256;
    pulse_sync();
    for (int k = 0; k < 3; k++) begin
      strobe();
      if (k == 0) begin
        chk("seq addr rd0", lut_addr, 0);
        @(posedge clk); #1;
        chk("seq addr rd1", lut_addr, 256);
      end
      wait_valid("seq", 16'(k), 16'(256 + k));
      idle(3);
    end

    // Wrap-around: the channel 0 address wraps past 1023, and channel 1 steps backwards.
    fcw1 = 32'hFFC0_0000; off1 = 10'd0; off0 = 10'd1020;
    pulse_sync();
    for (int k = 0; k < 5; k++) begin
      strobe();
      wait_valid("wrap", 16'(exp0[k]), 16'(exp1[k]));
      idle(2);
    end

    // Overrun: a second strobe while busy is dropped.
    fcw1 = 32'h0040_0000; off0 = 10'd100; off1 = 10'd200;
    pulse_sync();
    chk("overrun pre", ovr, 0);
    @(posedge clk); #1 tick = 1'b1; t_s = cyc;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    count_valid(10, nv);
    chk("overrun one valid", 32'(nv), 1);
    chk("overrun data", {ch0, ch1}, {16'd100, 16'd200});
    repeat (20) begin
      @(negedge clk);
      chk("overrun sticky", ovr, 1);
    end

    // Phase clear during the channel 1 read: no valid, outputs held, and the next strobe restarts at the offsets.
    @(posedge clk); #1;
    off0 = 10'd5; off1 = 10'd7;
    strobe();
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
    count_valid(6, nv);
    chk("sync no valid", 32'(nv), 0);
    chk("sync held", {ch0, ch1}, {16'd100, 16'd200});
    strobe();
    wait_valid("post-sync", 16'd5, 16'd7);

    // Deasserting enable mid-sequence does not stop the sequence from completing.
    strobe();
    en = 1'b0;
    wait_valid("en drop", 16'd6, 16'd8);
    en = 1'b1;

    // Asynchronous reset in the channel 0 read cycle.
    strobe();
    chk("pre-reset addr", lut_addr, 7);
    #2 rst = 1'b1;
    #1;
    chk("async ch0", ch0, 0);
    chk("async ch1", ch1, 0);
    chk("async valid/busy/ovr", {valid, busy, ovr}, 0);
    chk("async addr", lut_addr, 0);
    @(negedge clk); #2 rst = 1'b0;
    strobe();
    chk("post-reset addr", lut_addr, 5);
    wait_valid("post-reset", 16'd5, 16'd7);

    // While enable is low, strobes are ignored silently.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe();
      chk("en low busy", busy, 0);
      count_valid(6, nv);
      chk("en low no valid", 32'(nv), 0);
    end
    chk("en low overrun", ovr, 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
